// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states and default width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_fs.sv
// Single-bit full subtractor cell (borrow counterpart of the full adder), gate level.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a (minuend bit), b (subtrahend bit), bin (borrow in),
//        diff (a ^ b ^ bin), bout (borrow out).
module fs (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic a_x_b;
    logic a_n;
    logic p_ab;
    logic p_abin;
    logic p_bbin;

    xor g_x0 (a_x_b, a, b);
    xor g_x1 (diff, a_x_b, bin);

    // Borrow out when (~a & b) | (~a & bin) | (b & bin).
    not g_n0 (a_n, a);
    and g_a0 (p_ab, a_n, b);
    and g_a1 (p_abin, a_n, bin);
    and g_a2 (p_bbin, b, bin);
    or  g_o0 (bout, p_ab, p_abin, p_bbin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: diff = a - b mod 2^WIDTH, bout = (a < b), LSB first.
// Latency: start accepted at edge k -> done high between edges k+WIDTH and k+WIDTH+1.
// Backpressure: none; start is only sampled in IDLE, requests while busy/done are dropped.
// Ports: clk, rst (sync, active-high), start, a, b (operands, captured on accepted start),
//        busy (bits in flight), done (one-cycle result strobe), diff, bout (held results).
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_nxt;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             cell_d;
    logic             cell_bo;

    fs u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow),
        .diff (cell_d),
        .bout (cell_bo)
    );

    assign last_bit = (cnt == LAST);

    // Difference bits enter at the MSB end; after WIDTH shifts bit 0 sits at the LSB.
    assign work_nxt = (work >> 1) | {cell_d, {(WIDTH - 1){1'b0}}};

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            work   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        work   <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    work   <= work_nxt;
                    borrow <= cell_bo;
                    cnt    <= cnt + CW'(1);
                    // Published results only move on the final bit, so they stay
                    // stable for the whole operation.
                    if (last_bit) begin
                        diff <= work_nxt;
                        bout <= cell_bo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int vectors;
    int miscompares;

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain arithmetic on the unsigned operands.
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned r;
        r = (int'(x) - int'(y) + 256) % 256;
        return r[W-1:0];
    endfunction

    function automatic logic ref_bout(input logic [W-1:0] x, input logic [W-1:0] y);
        return int'(x) < int'(y);
    endfunction

    // Issues one request from IDLE, scrambles the operand inputs afterwards, and
    // reports result, cycles from acceptance to done, and cycles seen busy.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          output logic [W-1:0] od, output logic ob,
                          output int lat, output int busy_n);
        a = ia;
        b = ib;
        start = 1'b1;
        step();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        lat = 0;
        busy_n = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_n++;
            step();
            lat++;
        end
        od = diff;
        ob = bout;
        step();
    endtask

    task automatic test_reset();
        logic [W-1:0] od;
        logic ob;
        int lat, bn;
        rst = 1'b1;
        start = 1'b1;
        a = 8'h77;
        b = 8'h11;
        repeat (3) step();
        vectors++;
        if ({busy, done, diff, bout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bout=%b, want all 0",
                     busy, done, diff, bout);
        end
        // Start asserted right in the first cycle after reset release.
        rst = 1'b0;
        run_op(8'h05, 8'h03, od, ob, lat, bn);
        vectors++;
        if (lat !== W || bn !== W) begin
            miscompares++;
            $display("FAIL reset_first_start_latency: got lat=%0d busy=%0d, want %0d/%0d",
                     lat, bn, W, W);
        end
        vectors++;
        if (od !== 8'h02 || ob !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_first_start_result: got diff=%h bout=%b, want 02/0", od, ob);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        logic [W-1:0] ed [4];
        logic         eb [4];
        logic [W-1:0] od;
        logic ob;
        int lat, bn;
        ta = '{8'h05, 8'h03, 8'h00, 8'hFF};
        tb = '{8'h03, 8'h05, 8'hFF, 8'hFF};
        ed = '{8'h02, 8'hFE, 8'h01, 8'h00};
        eb = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], od, ob, lat, bn);
            vectors++;
            if (od !== ed[i] || ob !== eb[i]) begin
                miscompares++;
                $display("FAIL directed_%0d: got diff=%h bout=%b, want %h/%b",
                         i, od, ob, ed[i], eb[i]);
            end
            vectors++;
            if (lat !== W || bn !== W || done !== 1'b0) begin
                miscompares++;
                $display("FAIL directed_timing_%0d: got lat=%0d busy=%0d done_after=%b, want %0d/%0d/0",
                         i, lat, bn, done, W, W);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        bit held_ok;
        a = 8'h40;
        b = 8'h01;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        // Third SHIFT cycle: a second request that must be dropped.
        a = 8'h10;
        b = 8'h01;
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 3;
        held_ok = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (diff !== 8'h00 || bout !== 1'b0) held_ok = 1'b0;
            step();
            lat++;
        end
        vectors++;
        if (!held_ok) begin
            miscompares++;
            $display("FAIL ignore_hold_during_shift: diff/bout moved before done, want 00/0 held");
        end
        vectors++;
        if (lat !== W || diff !== 8'h3F || bout !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_first_result: got lat=%0d diff=%h bout=%b, want %0d/3f/0",
                     lat, diff, bout, W);
        end
        step();
        held_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (busy !== 1'b0 || done !== 1'b0) held_ok = 1'b0;
            step();
        end
        vectors++;
        if (!held_ok || diff !== 8'h3F) begin
            miscompares++;
            $display("FAIL ignore_no_queued_op: extra activity seen or diff=%h, want idle with 3f", diff);
        end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] od;
        logic ob;
        int lat, bn;
        bit quiet;
        a = 8'hAA;
        b = 8'h0F;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        start = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        vectors++;
        if ({busy, done, diff, bout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL midreset_outputs: got busy=%b done=%b diff=%h bout=%b, want all 0",
                     busy, done, diff, bout);
        end
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
            step();
        end
        vectors++;
        if (!quiet) begin
            miscompares++;
            $display("FAIL midreset_no_done: activity after abort, want none");
        end
        run_op(8'h0F, 8'hAA, od, ob, lat, bn);
        vectors++;
        if (od !== 8'h65 || ob !== 1'b1 || lat !== W) begin
            miscompares++;
            $display("FAIL midreset_fresh_op: got diff=%h bout=%b lat=%0d, want 65/1/%0d",
                     od, ob, lat, W);
        end
    endtask

    task automatic test_back_to_back();
        int pulses [$];
        bit vals_ok;
        a = 8'h5A;
        b = 8'hA5;
        vals_ok = 1'b1;
        start = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            if (i > 30) start = 1'b0;
            step();
            if (done === 1'b1) begin
                pulses.push_back(i);
                if (diff !== ref_diff(8'h5A, 8'hA5) || bout !== ref_bout(8'h5A, 8'hA5))
                    vals_ok = 1'b0;
            end
        end
        vectors++;
        if (pulses.size() != 3) begin
            miscompares++;
            $display("FAIL b2b_pulse_count: got %0d, want 3", pulses.size());
        end else begin
            vectors++;
            if (pulses[0] != W + 1 || pulses[1] - pulses[0] != W + 2 ||
                pulses[2] - pulses[1] != W + 2) begin
                miscompares++;
                $display("FAIL b2b_spacing: got edges %0d,%0d,%0d, want %0d,%0d,%0d",
                         pulses[0], pulses[1], pulses[2], W + 1, 2 * W + 3, 3 * W + 5);
            end
        end
        vectors++;
        if (!vals_ok) begin
            miscompares++;
            $display("FAIL b2b_values: diff/bout wrong at a done pulse, want %h/%b",
                     ref_diff(8'h5A, 8'hA5), ref_bout(8'h5A, 8'hA5));
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, od;
        logic ob;
        int lat, bn;
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 50 == 0) rb = ra;
            run_op(ra, rb, od, ob, lat, bn);
            vectors++;
            if (od !== ref_diff(ra, rb) || ob !== ref_bout(ra, rb) || lat !== W) begin
                miscompares++;
                $display("FAIL random_%0d: a=%h b=%h got diff=%h bout=%b lat=%0d, want %h/%b/%0d",
                         i, ra, rb, od, ob, lat, ref_diff(ra, rb), ref_bout(ra, rb), W);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to subtract; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; sampled on the accepted start edge.
REQ-006 b  input  WIDTH  subtrahend; sampled on the accepted start edge.
REQ-007 busy  output  1  high while bits are being processed.
REQ-008 done  output  1  single-cycle pulse; result valid.
REQ-009 diff  output  WIDTH  a minus b, modulo 2^WIDTH.
REQ-010 bout  output  1  final borrow; 1 when a < b, unsigned.

Function
REQ-011 Computation SHALL be bit-serial, LSB first, with one bit per clock through one full-subtractor cell.
- Cell equations: d = x^y^bin; bo = (~x&y) | (~x&bin) | (y&bin).
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE, encoded in 2 bits.
REQ-013 IDLE->SHIFT SHALL occur on an edge with start=1.
- a and b load into shift registers.
- Borrow register clears to 0; bit counter clears to 0.
REQ-014 In SHIFT, each edge SHALL:
- consume the operand LSBs;
- shift the difference bit into the working register MSB end;
- update the borrow register;
- increment the counter.
REQ-015 After the edge processing bit WIDTH-1, the FSM SHALL go SHIFT->DONE on that same edge.
- On that edge, diff and bout load from the working register and the borrow.
REQ-016 DONE->IDLE SHALL occur unconditionally on the next edge.
REQ-017 Latency: for start accepted at edge k, done SHALL be high only in the cycle between edges k+WIDTH and k+WIDTH+1.
REQ-018 busy SHALL equal (state==SHIFT); done SHALL equal (state==DONE); both are registered-state decodes.
REQ-019 start while in SHIFT or DONE SHALL be ignored, with no queuing.
- Back-to-back requests therefore have a throughput of one per WIDTH+2 cycles.
REQ-020 diff and bout SHALL hold the last result until the next DONE entry.
- They SHALL NOT change during SHIFT.
REQ-021 Changes on a and b after the accepted start edge SHALL NOT affect the result.
REQ-022 Counter width SHALL be $clog2(WIDTH+1).
- Terminal compare is against WIDTH-1; no wrap-around within one operation.

Reset
REQ-023 While rst=1 at an edge:
- state SHALL become IDLE;
- busy=0, done=0, diff=0, bout=0;
- counter, borrow and shift registers SHALL clear.
REQ-024 rst SHALL take priority over start.
- Reset mid-SHIFT SHALL abort the operation with no done pulse.
REQ-025 start asserted in the first cycle after rst deasserts SHALL be accepted.

Structure
REQ-026 A shared package SHALL hold the state enumeration (IDLE=0, SHIFT=1, DONE=2) and the default WIDTH constant.
REQ-027 The single-bit cell SHALL be a sub-module fs (ports a, b, bin, diff, bout) built from primitive gates.
- It is the borrow counterpart of the existing full-adder cell.
REQ-028 No other sub-modules SHALL be used; the FSM, counter and shift registers stay in serial_sub.

Verification
REQ-029 WIDTH=8: a=0x05, b=0x03, start for 1 cycle -> busy high for 8 cycles, then done for 1 cycle with diff=0x02, bout=0.
REQ-030 a=0x03, b=0x05 -> diff=0xFE, bout=1; a=0x00, b=0xFF -> diff=0x01, bout=1; a=0xFF, b=0xFF -> diff=0x00, bout=0.
REQ-031 start re-pulsed at SHIFT cycle 3 with a=0x10, b=0x01 -> ignored; first result still produced at the original latency.
REQ-032 rst asserted at SHIFT cycle 4 -> next cycle state IDLE, outputs all 0, no done pulse; a fresh start then completes normally.
REQ-033 start held high continuously for 30 cycles -> done pulses spaced exactly 10 cycles apart.
REQ-034 Random sweep of 1000 operand pairs -> every diff/bout matches (a-b) mod 256 and (a<b) from a scoreboard.
